// File: rtl/uint_cmp_pkg.sv
// uint_cmp_pkg: shared definitions for the streaming unsigned/signed compare.
//   MODE_W      width of the relation-select field
//   cmp_mode_e  relation encoding carried on MODE
package uint_cmp_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_ULT = 3'd2,
        CMP_ULE = 3'd3,
        CMP_UGT = 3'd4,
        CMP_UGE = 3'd5,
        CMP_SLT = 3'd6,   // two's complement
        CMP_SGE = 3'd7    // two's complement
    } cmp_mode_e;

endpackage

// File: rtl/uint_cmp_stream_core.sv
// uint_cmp_core: purely combinational relation evaluator.
//   i_a, i_b  operands (WIDTH bits)
//   i_mode    relation select (cmp_mode_e encoding)
//   o_res     1 when "i_a <relation> i_b" holds
module uint_cmp_core
    import uint_cmp_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [MODE_W-1:0] i_mode,
    output logic              o_res
);

    logic w_eq;
    logic w_ult;
    logic w_slt;

    assign w_eq  = (i_a == i_b);
    assign w_ult = (i_a < i_b);
    assign w_slt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_res = 1'b0;
        case (cmp_mode_e'(i_mode))
            CMP_EQ:  o_res = w_eq;
            CMP_NE:  o_res = !w_eq;
            CMP_ULT: o_res = w_ult;
            CMP_ULE: o_res = w_ult || w_eq;
            CMP_UGT: o_res = !(w_ult || w_eq);
            CMP_UGE: o_res = !w_ult;
            CMP_SLT: o_res = w_slt;
            CMP_SGE: o_res = !w_slt;
            default: o_res = 1'b0;
        endcase
    end

endmodule

// File: rtl/uint_cmp_stream.sv
// uint_cmp_stream: streaming compare with a 2-entry result FIFO and a
// saturating count of delivered true results.
//   CLK, ASYNCRESET         clock, async active-high reset
//   in_valid/in_ready       operand handshake (I0, I1, MODE)
//   out_valid/out_ready     result handshake (O = FIFO head, 0 when empty)
//   clear                   synchronous clear of match_count
//   match_count             saturating count of popped O==1 results
module uint_cmp_stream
    import uint_cmp_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     I0,
    input  logic [WIDTH-1:0]     I1,
    input  logic [MODE_W-1:0]    MODE,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 O,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] match_count
);

    logic                 r_mem [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_occ;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic w_res;
    logic w_push;
    logic w_pop;
    logic w_head;

    uint_cmp_core #(.WIDTH(WIDTH)) u_core (
        .i_a    (I0),
        .i_b    (I1),
        .i_mode (MODE),
        .o_res  (w_res)
    );

    // Handshake flags depend on registered occupancy only.
    assign in_ready  = (r_occ != 2'd2);
    assign out_valid = (r_occ != 2'd0);
    assign w_head    = r_mem[r_rd_ptr];
    assign O         = out_valid && w_head;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    assign match_count = r_cnt;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_mem[0] <= 1'b0;
            r_mem[1] <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_res;
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            // Push and pop together leave occupancy unchanged.
            r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
        end
    end

    // Clear wins over a coincident increment; counter sticks at all-ones.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (w_pop && w_head && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uint_cmp_stream.sv
module tb_uint_cmp_stream;

    logic       CLK = 1'b0;
    logic       ASYNCRESET;

    // Main instance: WIDTH=3, CNT_WIDTH=8
    logic       in_valid, in_ready, out_valid, out_ready, O, clear;
    logic [2:0] I0, I1, MODE;
    logic [7:0] match_count;

    // Counter instance: WIDTH=3, CNT_WIDTH=2
    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_O, c_clear;
    logic [2:0] c_I0, c_I1, c_MODE;
    logic [1:0] c_match_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    uint_cmp_stream #(.WIDTH(3), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .I0(I0), .I1(I1), .MODE(MODE),
        .out_valid(out_valid), .out_ready(out_ready), .O(O),
        .clear(clear), .match_count(match_count)
    );

    uint_cmp_stream #(.WIDTH(3), .CNT_WIDTH(2)) dut_cnt (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .I0(c_I0), .I1(c_I1), .MODE(c_MODE),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .O(c_O),
        .clear(c_clear), .match_count(c_match_count)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; out_ready = 0; clear = 0; I0 = 0; I1 = 0; MODE = 0;
        c_in_valid = 0; c_out_ready = 0; c_clear = 0; c_I0 = 0; c_I1 = 0; c_MODE = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ASYNCRESET = 1;
        tick();
        tick();
        ASYNCRESET = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ASYNCRESET = 1;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || O !== 1'b0 || match_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_init: out_valid=%b O=%b cnt=%0d want 0 0 0", out_valid, O, match_count);
        end
        tick();
        ASYNCRESET = 0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_init_ready: in_ready=%b want 1", in_ready);
        end
        // Deliver one true result so the counter is nonzero.
        in_valid = 1; I0 = 3'd4; I1 = 3'd4; MODE = 3'd0;
        tick();
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        n_checks++;
        if (match_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_precount: cnt=%0d want 1", match_count);
        end
        // Queue two entries, then reset asynchronously mid-cycle.
        in_valid = 1; I0 = 3'd1; I1 = 3'd1;
        tick();
        tick();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        #2;
        ASYNCRESET = 1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || O !== 1'b0 || match_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b O=%b cnt=%0d want 0 0 0", out_valid, O, match_count);
        end
        tick();
        ASYNCRESET = 0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_modes();
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        // bit m = expected result for MODE m
        exp_a = 8'b0111_0010;   // 101 vs 011
        exp_b = 8'b1010_1001;   // 110 vs 110
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int m = 0; m < 8; m++) begin
                in_valid = 1;
                I0 = (p == 0) ? 3'b101 : 3'b110;
                I1 = (p == 0) ? 3'b011 : 3'b110;
                MODE = 3'(m);
                tick();
                in_valid = 0; I0 = 'x; I1 = 'x; MODE = 'x;
                n_checks++;
                if (out_valid !== 1'b1 || O !== ((p == 0) ? exp_a[m] : exp_b[m])) begin
                    n_fail++;
                    $display("FAIL mode p%0d m%0d: out_valid=%b O=%b want 1 %b", p, m, out_valid, O,
                             (p == 0) ? exp_a[m] : exp_b[m]);
                end
                out_ready = 1;
                tick();
                out_ready = 0;
            end
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        MODE = 3'd0;
        // A=1 (3==3), B=0 (1!=2), C=1 (dropped while full)
        in_valid = 1; I0 = 3'd3; I1 = 3'd3;
        tick();
        I0 = 3'd1; I1 = 3'd2;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready1: in_ready=%b want 1", in_ready);
        end
        tick();
        I0 = 3'd5; I1 = 3'd5;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b want 0", in_ready);
        end
        tick();
        in_valid = 0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || O !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b O=%b want 0 1 1", in_ready, out_valid, O);
        end
        out_ready = 1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || O !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pop1: in_ready=%b out_valid=%b O=%b want 1 1 0", in_ready, out_valid, O);
        end
        tick();
        out_ready = 0;
        n_checks++;
        if (out_valid !== 1'b0 || match_count !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_drop: out_valid=%b cnt=%0d want 0 1", out_valid, match_count);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        MODE = 3'd0;
        in_valid = 1; out_ready = 1;
        // pair i is equal exactly when i%3==0
        for (int i = 0; i < 16; i++) begin
            I0 = 3'(i);
            I1 = (i % 3 == 0) ? 3'(i) : 3'(i + 1);
            if (i > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1 || O !== ((i - 1) % 3 == 0)) begin
                    n_fail++;
                    $display("FAIL stream_%0d: out_valid=%b in_ready=%b O=%b want 1 1 %b",
                             i - 1, out_valid, in_ready, O, ((i - 1) % 3 == 0));
                end
            end
            tick();
        end
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || O !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_15: out_valid=%b O=%b want 1 1", out_valid, O);
        end
        tick();
        out_ready = 0;
        n_checks++;
        if (out_valid !== 1'b0 || match_count !== 8'd6) begin
            n_fail++;
            $display("FAIL stream_end: out_valid=%b cnt=%0d want 0 6", out_valid, match_count);
        end
    endtask

    task automatic test_counter();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        c_MODE = 3'd0; c_I0 = 3'd2; c_I1 = 3'd2;
        for (int k = 0; k < 5; k++) begin
            c_in_valid = 1;
            tick();
            c_in_valid = 0; c_out_ready = 1;
            tick();
            c_out_ready = 0;
            n_checks++;
            if (c_match_count !== exp_cnt[k]) begin
                n_fail++;
                $display("FAIL cnt_%0d: cnt=%0d want %0d", k, c_match_count, exp_cnt[k]);
            end
        end
        // Clear coincident with a true pop wins.
        c_in_valid = 1;
        tick();
        c_in_valid = 0; c_out_ready = 1; c_clear = 1;
        tick();
        c_out_ready = 0; c_clear = 0;
        n_checks++;
        if (c_match_count !== 2'd0 || c_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_clear: cnt=%0d out_valid=%b want 0 0", c_match_count, c_out_valid);
        end
        // False results do not count.
        c_I1 = 3'd3;
        c_in_valid = 1;
        tick();
        c_in_valid = 0; c_out_ready = 1;
        tick();
        c_out_ready = 0;
        n_checks++;
        if (c_match_count !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_false: cnt=%0d want 0", c_match_count);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_streaming();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim_time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
